// File: rtl/fir_sterowanie_mc.sv
// rtl/fir_sterowanie_mc.sv - multi-channel sequencing FSM for the FIR datapath
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   START, ABORT        run request (IDLE only) / abort of the current run
//   tryb, n_probek      run mode (0 single-shot, 1 continuous) and samples per
//                       channel, both latched when a run starts
//   probka_valid        new input sample present (continuous mode)
//   wyj_ready           output sink accepts the pending write
//   pracuje, DONE       busy flag / one-cycle end-of-run pulse
//   FSM_MUX_*           datapath bus selects (1 = FIR owns the bus)
//   FSM_*               datapath strobes (load, shift, accumulate, store, write)
//   tap_idx, ch_idx,    current tap, channel and sample indices
//   probka_idx

module fir_sterowanie_mc #(
  parameter int N_TAPS       = 16,
  parameter int N_CH         = 1,
  parameter int SAMPLE_CNT_W = 16,
  parameter int DECIM        = 1,
  localparam int TAP_W = (N_TAPS > 1) ? $clog2(N_TAPS) : 1,
  localparam int CH_W  = (N_CH > 1)   ? $clog2(N_CH)   : 1,
  localparam int DEC_W = (DECIM > 1)  ? $clog2(DECIM)  : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    START,
  input  logic                    ABORT,
  input  logic                    tryb,
  input  logic [SAMPLE_CNT_W-1:0] n_probek,
  input  logic                    probka_valid,
  input  logic                    wyj_ready,
  output logic                    pracuje,
  output logic                    DONE,
  output logic                    FSM_MUX_wej,
  output logic                    FSM_MUX_wyj,
  output logic                    FSM_MUX_CDC,
  output logic                    FSM_zapisz_wsp,
  output logic                    FSM_zapisz_probki,
  output logic                    FSM_nowa_shift,
  output logic                    FSM_Acc_en,
  output logic                    FSM_Acc_zapisz,
  output logic                    FSM_reset_Acc,
  output logic                    FSM_nowa_probka,
  output logic                    FSM_wyj_wr,
  output logic [TAP_W-1:0]        tap_idx,
  output logic [CH_W-1:0]         ch_idx,
  output logic [SAMPLE_CNT_W-1:0] probka_idx
);

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    SHIFT,
    MAC,
    SAVE,
    WRITE,
    NEXT,
    KONIEC
  } state_t;

  localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(N_TAPS - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(N_CH - 1);
  localparam logic [DEC_W-1:0] DEC_LAST = DEC_W'(DECIM - 1);

  state_t                  state;
  state_t                  state_nxt;
  logic [TAP_W-1:0]        tap_cnt;
  logic [CH_W-1:0]         ch_cnt;
  logic [SAMPLE_CNT_W-1:0] smp_cnt;
  // Tracks smp_cnt mod DECIM incrementally so no divider is needed.
  logic [DEC_W-1:0]        dec_cnt;
  logic                    tryb_q;
  logic [SAMPLE_CNT_W-1:0] n_q;

  logic last_tap;
  logic last_ch;
  logic last_smp;
  logic dec_hit;

  assign last_tap = (tap_cnt == TAP_LAST);
  assign last_ch  = (ch_cnt == CH_LAST);
  assign last_smp = (smp_cnt == (n_q - SAMPLE_CNT_W'(1)));
  assign dec_hit  = (dec_cnt == DEC_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      tap_cnt <= '0;
      ch_cnt  <= '0;
      smp_cnt <= '0;
      dec_cnt <= '0;
      tryb_q  <= 1'b0;
      n_q     <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && state_nxt == INIT) begin
        tryb_q <= tryb;
        n_q    <= n_probek;
      end
      case (state)
        INIT: begin
          tap_cnt <= '0;
          ch_cnt  <= '0;
          smp_cnt <= '0;
          dec_cnt <= '0;
        end
        MAC: begin
          // Tap index parks on the last tap until NEXT clears it.
          if (!last_tap) begin
            tap_cnt <= tap_cnt + TAP_W'(1);
          end
        end
        NEXT: begin
          tap_cnt <= '0;
          if (last_ch) begin
            ch_cnt <= '0;
            if (last_smp) begin
              // End of a pass: continuous runs restart the sample and
              // decimation phase from zero.
              smp_cnt <= '0;
              dec_cnt <= '0;
            end else begin
              smp_cnt <= smp_cnt + SAMPLE_CNT_W'(1);
              dec_cnt <= dec_hit ? '0 : dec_cnt + DEC_W'(1);
            end
          end else begin
            ch_cnt <= ch_cnt + CH_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (START && !ABORT) begin
          state_nxt = INIT;
        end
      end
      INIT: begin
        state_nxt = (n_q == '0) ? KONIEC : SHIFT;
      end
      SHIFT: begin
        if (!tryb_q || probka_valid) begin
          state_nxt = MAC;
        end
      end
      MAC: begin
        if (last_tap) begin
          state_nxt = SAVE;
        end
      end
      SAVE: begin
        state_nxt = dec_hit ? WRITE : NEXT;
      end
      WRITE: begin
        if (wyj_ready) begin
          state_nxt = NEXT;
        end
      end
      NEXT: begin
        if (last_ch && last_smp && !tryb_q) begin
          state_nxt = KONIEC;
        end else begin
          state_nxt = SHIFT;
        end
      end
      KONIEC: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    // Abort wins over every other transition, including a write accept.
    if (ABORT && state != IDLE) begin
      state_nxt = IDLE;
    end
  end

  always_comb begin
    pracuje           = 1'b0;
    DONE              = 1'b0;
    FSM_MUX_wej       = 1'b0;
    FSM_MUX_wyj       = 1'b0;
    FSM_MUX_CDC       = 1'b0;
    FSM_zapisz_wsp    = 1'b0;
    FSM_zapisz_probki = 1'b0;
    FSM_nowa_shift    = 1'b0;
    FSM_Acc_en        = 1'b0;
    FSM_Acc_zapisz    = 1'b0;
    FSM_reset_Acc     = 1'b0;
    FSM_nowa_probka   = 1'b0;
    FSM_wyj_wr        = 1'b0;
    tap_idx           = '0;
    ch_idx            = '0;
    probka_idx        = '0;
    if (state != IDLE) begin
      FSM_MUX_wej = 1'b1;
      FSM_MUX_wyj = 1'b1;
      FSM_MUX_CDC = 1'b1;
      pracuje     = (state != KONIEC);
      tap_idx     = tap_cnt;
      ch_idx      = ch_cnt;
      probka_idx  = smp_cnt;
    end
    case (state)
      INIT: begin
        FSM_zapisz_wsp    = 1'b1;
        FSM_zapisz_probki = 1'b1;
        FSM_reset_Acc     = 1'b1;
      end
      SHIFT:  FSM_nowa_shift = !tryb_q || probka_valid;
      MAC:    FSM_Acc_en = 1'b1;
      SAVE: begin
        FSM_Acc_zapisz  = 1'b1;
        FSM_nowa_probka = 1'b1;
      end
      WRITE:  FSM_wyj_wr = 1'b1;
      NEXT:   FSM_reset_Acc = 1'b1;
      KONIEC: DONE = 1'b1;
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_fir_sterowanie_mc.sv
// tb/tb_fir_sterowanie_mc.sv - directed self-checking bench for fir_sterowanie_mc

module tb_fir_sterowanie_mc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start1 = 1'b0;
  logic        start2 = 1'b0;
  logic        abort_r = 1'b0;
  logic        tryb = 1'b0;
  logic [15:0] n_probek = 16'd0;
  logic        probka_valid = 1'b0;
  logic        wyj_ready = 1'b1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // DUT 1: N_TAPS=4, N_CH=1, DECIM=1
  logic        d1_pr, d1_done, d1_mw, d1_my, d1_mc, d1_zw, d1_zp, d1_sh;
  logic        d1_acc, d1_az, d1_ra, d1_np, d1_wr;
  logic [1:0]  d1_tap;
  logic [0:0]  d1_ch;
  logic [15:0] d1_idx;
  logic [31:0] d1_all;
  assign d1_all = {d1_pr, d1_done, d1_mw, d1_my, d1_mc, d1_zw, d1_zp, d1_sh,
                   d1_acc, d1_az, d1_ra, d1_np, d1_wr, d1_tap, d1_ch, d1_idx};

  fir_sterowanie_mc #(.N_TAPS(4), .N_CH(1), .SAMPLE_CNT_W(16), .DECIM(1)) dut (
    .clk(clk), .rst(rst), .START(start1), .ABORT(abort_r), .tryb(tryb),
    .n_probek(n_probek), .probka_valid(probka_valid), .wyj_ready(wyj_ready),
    .pracuje(d1_pr), .DONE(d1_done), .FSM_MUX_wej(d1_mw), .FSM_MUX_wyj(d1_my),
    .FSM_MUX_CDC(d1_mc), .FSM_zapisz_wsp(d1_zw), .FSM_zapisz_probki(d1_zp),
    .FSM_nowa_shift(d1_sh), .FSM_Acc_en(d1_acc), .FSM_Acc_zapisz(d1_az),
    .FSM_reset_Acc(d1_ra), .FSM_nowa_probka(d1_np), .FSM_wyj_wr(d1_wr),
    .tap_idx(d1_tap), .ch_idx(d1_ch), .probka_idx(d1_idx)
  );

  // DUT 2: N_TAPS=4, N_CH=2, DECIM=2
  logic        d2_pr, d2_done, d2_mw, d2_my, d2_mc, d2_zw, d2_zp, d2_sh;
  logic        d2_acc, d2_az, d2_ra, d2_np, d2_wr;
  logic [1:0]  d2_tap;
  logic [0:0]  d2_ch;
  logic [15:0] d2_idx;
  logic [31:0] d2_all;
  assign d2_all = {d2_pr, d2_done, d2_mw, d2_my, d2_mc, d2_zw, d2_zp, d2_sh,
                   d2_acc, d2_az, d2_ra, d2_np, d2_wr, d2_tap, d2_ch, d2_idx};

  fir_sterowanie_mc #(.N_TAPS(4), .N_CH(2), .SAMPLE_CNT_W(16), .DECIM(2)) dut2 (
    .clk(clk), .rst(rst), .START(start2), .ABORT(abort_r), .tryb(tryb),
    .n_probek(n_probek), .probka_valid(probka_valid), .wyj_ready(wyj_ready),
    .pracuje(d2_pr), .DONE(d2_done), .FSM_MUX_wej(d2_mw), .FSM_MUX_wyj(d2_my),
    .FSM_MUX_CDC(d2_mc), .FSM_zapisz_wsp(d2_zw), .FSM_zapisz_probki(d2_zp),
    .FSM_nowa_shift(d2_sh), .FSM_Acc_en(d2_acc), .FSM_Acc_zapisz(d2_az),
    .FSM_reset_Acc(d2_ra), .FSM_nowa_probka(d2_np), .FSM_wyj_wr(d2_wr),
    .tap_idx(d2_tap), .ch_idx(d2_ch), .probka_idx(d2_idx)
  );

  // Pulses START on the chosen DUT; the edge it is sampled on is edge 0, so
  // the next negedge observes cycle 1. n_probek is then scrambled to show
  // that only the latched value matters.
  task automatic kick(input bit sel, input logic [15:0] n, input bit t);
    @(negedge clk);
    n_probek = n;
    tryb     = t;
    if (sel) start2 = 1'b1;
    else     start1 = 1'b1;
    @(posedge clk);
    #1;
    start1   = 1'b0;
    start2   = 1'b0;
    n_probek = 16'd7;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle_cycles(3);
    @(negedge clk);
    #1;
    checks++;
    if (d1_all !== 32'h0) begin
      errors++;
      $display("FAIL reset_dut1 got %h expected %h", d1_all, 32'h0);
    end
    checks++;
    if (d2_all !== 32'h0) begin
      errors++;
      $display("FAIL reset_dut2 got %h expected %h", d2_all, 32'h0);
    end
    rst = 1'b0;
  endtask

  task automatic test_start_abort_idle;
    @(negedge clk);
    start1  = 1'b1;
    abort_r = 1'b1;
    @(posedge clk);
    #1;
    start1  = 1'b0;
    abort_r = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if (d1_all !== 32'h0) begin
        errors++;
        $display("FAIL start_abort_idle cycle %0d got %h expected %h", c, d1_all, 32'h0);
      end
    end
  endtask

  task automatic test_single_shot;
    int writes;
    int acc_run;
    logic exp_pr, exp_done, exp_wr;
    writes  = 0;
    acc_run = 0;
    kick(1'b0, 16'd3, 1'b0);
    tryb = 1'b1;  // must be ignored mid-run
    probka_valid = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      wyj_ready = 1'b1;
      #1;
      exp_pr   = (c >= 1 && c <= 25);
      exp_done = (c == 26);
      exp_wr   = (c == 8 || c == 16 || c == 24);
      checks++;
      if (d1_pr !== exp_pr) begin
        errors++;
        $display("FAIL ss_pracuje cycle %0d got %b expected %b", c, d1_pr, exp_pr);
      end
      checks++;
      if (d1_done !== exp_done) begin
        errors++;
        $display("FAIL ss_done cycle %0d got %b expected %b", c, d1_done, exp_done);
      end
      checks++;
      if (d1_wr !== exp_wr) begin
        errors++;
        $display("FAIL ss_wr cycle %0d got %b expected %b", c, d1_wr, exp_wr);
      end
      if (d1_acc === 1'b1) acc_run++;
      if (d1_wr === 1'b1) begin
        checks++;
        if (d1_idx !== 16'(writes)) begin
          errors++;
          $display("FAIL ss_wr_idx got %0d expected %0d", d1_idx, writes);
        end
        checks++;
        if (acc_run != 4) begin
          errors++;
          $display("FAIL ss_acc_before_wr got %0d expected %0d", acc_run, 4);
        end
        acc_run = 0;
        writes++;
      end
    end
    checks++;
    if (writes != 3) begin
      errors++;
      $display("FAIL ss_write_count got %0d expected %0d", writes, 3);
    end
    tryb = 1'b0;
  endtask

  task automatic test_backpressure;
    int writes;
    logic exp_done, exp_wr;
    logic [1:0] tap_hold;
    writes   = 0;
    tap_hold = '0;
    kick(1'b0, 16'd3, 1'b0);
    for (int c = 1; c <= 34; c++) begin
      @(negedge clk);
      wyj_ready = !(c >= 8 && c <= 12);
      #1;
      exp_done = (c == 31);
      exp_wr   = (c >= 8 && c <= 13) || c == 21 || c == 29;
      checks++;
      if (d1_done !== exp_done) begin
        errors++;
        $display("FAIL bp_done cycle %0d got %b expected %b", c, d1_done, exp_done);
      end
      checks++;
      if (d1_wr !== exp_wr) begin
        errors++;
        $display("FAIL bp_wr cycle %0d got %b expected %b", c, d1_wr, exp_wr);
      end
      if (c == 8) tap_hold = d1_tap;
      if (c >= 8 && c <= 13) begin
        checks++;
        if (d1_tap !== tap_hold) begin
          errors++;
          $display("FAIL bp_tap_frozen cycle %0d got %0d expected %0d", c, d1_tap, tap_hold);
        end
        checks++;
        if (d1_acc !== 1'b0) begin
          errors++;
          $display("FAIL bp_acc_en cycle %0d got %b expected %b", c, d1_acc, 1'b0);
        end
      end
      if (d1_wr === 1'b1 && wyj_ready) writes++;
    end
    wyj_ready = 1'b1;
    checks++;
    if (writes != 3) begin
      errors++;
      $display("FAIL bp_write_count got %0d expected %0d", writes, 3);
    end
  endtask

  task automatic test_decim_multi_ch;
    int nwr;
    int nzap;
    int exp_ch[4];
    int exp_pr[4];
    logic exp_done;
    exp_ch = '{0, 1, 0, 1};
    exp_pr = '{1, 1, 3, 3};
    nwr  = 0;
    nzap = 0;
    kick(1'b1, 16'd4, 1'b0);
    for (int c = 1; c <= 66; c++) begin
      @(negedge clk);
      wyj_ready = 1'b1;
      #1;
      exp_done = (c == 62);
      checks++;
      if (d2_done !== exp_done) begin
        errors++;
        $display("FAIL dec_done cycle %0d got %b expected %b", c, d2_done, exp_done);
      end
      if (d2_az === 1'b1) nzap++;
      if (d2_wr === 1'b1) begin
        checks++;
        if (nwr >= 4) begin
          errors++;
          $display("FAIL dec_extra_write got %0d expected %0d", nwr + 1, 4);
        end else if (d2_ch !== 1'(exp_ch[nwr]) || d2_idx !== 16'(exp_pr[nwr])) begin
          errors++;
          $display("FAIL dec_write_%0d got (%0d,%0d) expected (%0d,%0d)",
                   nwr, d2_ch, d2_idx, exp_ch[nwr], exp_pr[nwr]);
        end
        nwr++;
      end
    end
    checks++;
    if (nwr != 4) begin
      errors++;
      $display("FAIL dec_write_count got %0d expected %0d", nwr, 4);
    end
    checks++;
    if (nzap != 8) begin
      errors++;
      $display("FAIL dec_acc_zapisz_count got %0d expected %0d", nzap, 8);
    end
  endtask

  task automatic test_zero_samples;
    kick(1'b0, 16'd0, 1'b0);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      #1;
      if (c == 1) begin
        checks++;
        if (d1_zw !== 1'b1 || d1_pr !== 1'b1) begin
          errors++;
          $display("FAIL zero_init got zw=%b pr=%b expected zw=1 pr=1", d1_zw, d1_pr);
        end
      end
      checks++;
      if (d1_done !== (c == 2)) begin
        errors++;
        $display("FAIL zero_done cycle %0d got %b expected %b", c, d1_done, (c == 2));
      end
      checks++;
      if (d1_sh !== 1'b0) begin
        errors++;
        $display("FAIL zero_shift cycle %0d got %b expected %b", c, d1_sh, 1'b0);
      end
    end
  endtask

  task automatic test_abort;
    int writes;
    logic exp_done;
    kick(1'b0, 16'd3, 1'b0);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      abort_r = (c == 5);
      #1;
      if (c == 5) begin
        checks++;
        if (d1_acc !== 1'b1 || d1_tap !== 2'd2) begin
          errors++;
          $display("FAIL abort_third_mac got acc=%b tap=%0d expected acc=1 tap=2", d1_acc, d1_tap);
        end
      end
      if (c == 6) begin
        checks++;
        if (d1_all !== 32'h0) begin
          errors++;
          $display("FAIL abort_idle got %h expected %h", d1_all, 32'h0);
        end
      end
      if (c >= 6) begin
        checks++;
        if (d1_done !== 1'b0 || d1_pr !== 1'b0) begin
          errors++;
          $display("FAIL abort_quiet cycle %0d got done=%b pr=%b expected 0 0", c, d1_done, d1_pr);
        end
      end
    end
    abort_r = 1'b0;
    writes  = 0;
    kick(1'b0, 16'd3, 1'b0);
    for (int c = 1; c <= 28; c++) begin
      @(negedge clk);
      #1;
      exp_done = (c == 26);
      checks++;
      if (d1_done !== exp_done) begin
        errors++;
        $display("FAIL abort_rerun_done cycle %0d got %b expected %b", c, d1_done, exp_done);
      end
      if (d1_wr === 1'b1) begin
        checks++;
        if (d1_idx !== 16'(writes)) begin
          errors++;
          $display("FAIL abort_rerun_idx got %0d expected %0d", d1_idx, writes);
        end
        writes++;
      end
    end
    checks++;
    if (writes != 3) begin
      errors++;
      $display("FAIL abort_rerun_writes got %0d expected %0d", writes, 3);
    end
  endtask

  task automatic test_continuous;
    int nshift;
    logic [15:0] exp_idx;
    bit found;
    nshift  = 0;
    exp_idx = 16'd0;
    found   = 1'b0;
    kick(1'b0, 16'd2, 1'b1);
    tryb = 1'b0;  // latched value must keep the run continuous
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      probka_valid = ((c % 2) == 1);
      wyj_ready    = 1'b1;
      #1;
      if (d1_sh === 1'b1) begin
        checks++;
        if (probka_valid !== 1'b1) begin
          errors++;
          $display("FAIL cont_shift_no_valid cycle %0d got %b expected %b", c, probka_valid, 1'b1);
        end
        checks++;
        if (d1_idx !== exp_idx) begin
          errors++;
          $display("FAIL cont_idx cycle %0d got %0d expected %0d", c, d1_idx, exp_idx);
        end
        exp_idx = exp_idx ^ 16'd1;
        nshift++;
      end
      checks++;
      if (d1_done !== 1'b0 || d1_pr !== 1'b1) begin
        errors++;
        $display("FAIL cont_running cycle %0d got done=%b pr=%b expected 0 1", c, d1_done, d1_pr);
      end
    end
    checks++;
    if (nshift < 8) begin
      errors++;
      $display("FAIL cont_shift_count got %0d expected at least %0d", nshift, 8);
    end
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      #1;
      if (d1_acc === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL cont_find_mac got %b expected %b", found, 1'b1);
    end
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (d1_all !== 32'h0) begin
      errors++;
      $display("FAIL cont_rst_mid_mac got %h expected %h", d1_all, 32'h0);
    end
    rst          = 1'b0;
    probka_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_start_abort_idle();
    test_single_shot();
    idle_cycles(2);
    test_backpressure();
    idle_cycles(2);
    test_decim_multi_ch();
    idle_cycles(2);
    test_zero_samples();
    idle_cycles(2);
    test_abort();
    idle_cycles(2);
    test_continuous();
    idle_cycles(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
